instr_mem_responder: RTL
========================

Name: instr_mem_responder

Overview:
- Instruction-side memory responder. It is the slave end of the CPU fetch interface that the program counter drives.
- Accepts word-aligned fetch reads on an Avalon-style read/waitrequest handshake. Returns 32-bit instructions from an internal word array mapped at the reset vector window.
- Inserts a configurable number of wait states.
- Provides a load port so benches and boot logic can fill the array before the CPU is released.

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address of array word 0.
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..65536.
- WAIT_STATES, 2, extra busy cycles per read; 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  32  byte fetch address (pcout from CPU).
- read  input  1  fetch request; held with address stable until waitrequest low.
- waitrequest  output  1  high while the response is not ready.
- readdata  output  32  instruction; valid only when read=1 and waitrequest=0.
- err  output  1  response flag for misaligned or out-of-window fetch; qualified like readdata.
- load_en  input  1  write one word into the array.
- load_index  input  $clog2(DEPTH_WORDS)  word index for load.
- load_data  input  32  word to store.
- read_count  output  16  number of completed reads; wraps.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, busy counter=0, readdata=0, err=0, read_count=0.
  - waitrequest follows its combinational rule below.
  - Array contents are not cleared.
- waitrequest = read && (state != RESP). It is combinational, so it is high in the same cycle read first rises.
- Decode, computed combinationally from address:
  - off = address - BASE_ADDR (32-bit, wrapping).
  - in_window = (off >> 2) < DEPTH_WORDS.
  - aligned = (address[1:0] == 0).
  - index = off[2+:$clog2(DEPTH_WORDS)].
- States:
  - IDLE:
    - read=1 and WAIT_STATES=0 -> LATCH.
    - read=1 and WAIT_STATES>0 -> BUSY, counter loaded with WAIT_STATES-1.
  - BUSY:
    - read=0 -> IDLE (request aborted, nothing counted).
    - Otherwise, counter==0 -> LATCH; else decrement.
  - LATCH:
    - read=0 -> IDLE.
    - Else register the response: readdata=array[index] and err=0 when aligned && in_window; otherwise readdata=0 and err=1. Go to RESP.
  - RESP:
    - waitrequest=0; readdata/err hold their LATCH values.
    - Next state always IDLE. read_count increments by 1 if read=1 in this cycle (16-bit wrap 0xFFFF->0x0000).
- Latency:
  - Read first seen in cycle t -> waitrequest low in cycle t+WAIT_STATES+2.
  - One idle-state cycle is spent before the next request is accepted. Back-to-back fetches take WAIT_STATES+3 cycles each.
- Address changes while waitrequest is high are a protocol violation. The value sampled in LATCH is the one used; the responder does not check for changes.
- Load port:
  - Synchronous write on the clk edge when load_en=1, in any state.
  - If a load hits the same index on the same edge LATCH samples, readdata returns the old word; the new word is visible to later reads.
  - Load works independently of read.
- Reset mid-read:
  - The FSM returns to IDLE immediately and outputs clear.
  - If read is still high after reset_n rises, it is treated as a new request.
- Response contents are the raw array word. No endian swap or sign handling.

Test Plan:
- Preload index 0 = 32'h2402000A, index 1 = 32'h00000008. With WAIT_STATES=2, read at address BFC00000 in cycle 5 -> waitrequest high in cycles 5..8, low in cycle 9 with readdata 32'h2402000A and err=0; read_count=1 after cycle 9.
- Fetch 0xBFC00004 immediately after the previous response -> read sampled in the cycle after RESP; readdata 32'h00000008 returned 4 cycles later; read_count=2.
- Misaligned address 0xBFC00002 -> err=1, readdata=0 at response. Address 0xBFC00400 with DEPTH_WORDS=256 -> err=1, readdata=0. Address 0x00000000 -> err=1 (wrapped offset out of window).
- Drop read during BUSY, then reassert with address 0xBFC00004 -> full WAIT_STATES+2 latency restarts; read_count is not incremented for the aborted request.
- load_en to index 0 with 32'hDEADBEEF on the LATCH edge of a fetch of 0xBFC00000 -> that response returns 32'h2402000A; the next fetch returns 32'hDEADBEEF.
- Assert reset_n=0 asynchronously while in BUSY -> outputs clear before the next edge. Release with read held high -> fresh response at the full WAIT_STATES+2 latency. Also test WAIT_STATES=0: waitrequest low 2 cycles after read rises.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-side fetch responder: word array at the reset vector window,
// Avalon-style read/waitrequest handshake with programmable wait states,
// and a load port for filling the array before the CPU is released.
module instr_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      address,
  input  logic             read,
  output logic             waitrequest,
  output logic [31:0]      readdata,
  output logic             err,
  input  logic             load_en,
  input  logic [IDX_W-1:0] load_index,
  input  logic [31:0]      load_data,
  output logic [15:0]      read_count
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    LATCH = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               err_q, err_d;
  logic [15:0]        read_count_q, read_count_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [31:0]        off;
  logic               in_window;
  logic               aligned;
  logic [IDX_W-1:0]   index;

  // Address decode relative to the window base (offset wraps at 32 bits)
  assign off       = address - BASE_ADDR;
  assign in_window = (off >> 2) < 32'(DEPTH_WORDS);
  assign aligned   = (address[1:0] == 2'b00);
  assign index     = off[2 +: IDX_W];

  // Busy until the response cycle; combinational so it rises with read
  assign waitrequest = read && (state_q != RESP);
  assign readdata    = readdata_q;
  assign err         = err_q;
  assign read_count  = read_count_q;

  // Load port write; a same-edge LATCH read still sees the old word
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_index] <= load_data;
    end
  end

  // State and response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      readdata_q   <= '0;
      err_q        <= 1'b0;
      read_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      readdata_q   <= readdata_d;
      err_q        <= err_d;
      read_count_q <= read_count_d;
    end
  end

  // Next-state and response computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    readdata_d   = readdata_q;
    err_d        = err_q;
    read_count_d = read_count_q;
    unique case (state_q)
      IDLE: begin
        if (read) begin
          if (WAIT_STATES == 0) begin
            state_d = LATCH;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      BUSY: begin
        if (!read) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LATCH: begin
        if (!read) begin
          state_d = IDLE;
        end else begin
          if (aligned && in_window) begin
            readdata_d = mem[index];
            err_d      = 1'b0;
          end else begin
            readdata_d = '0;
            err_d      = 1'b1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (read) begin
          read_count_d = read_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
